// File: rtl/cascade_sequencer.sv
// Cascade stage sequencer: walks the stage ROM, streams feature indices to the
// feature fetcher and turns classifier stage verdicts into a window result.
module cascade_sequencer #(
    parameter int NUM_STAGES = 22,
    parameter int FEAT_W     = 12,
    parameter int SA_W       = $clog2(NUM_STAGES)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              face_o,
    output logic              err_o,
    output logic [SA_W-1:0]   stage_addr_o,
    output logic              stage_rd_o,
    input  logic              stage_rdata_val_i,
    input  logic [FEAT_W-1:0] stage_feat_cnt_i,
    input  logic [31:0]       stage_threshold_i,
    output logic [FEAT_W-1:0] feat_idx_o,
    output logic              feat_val_o,
    input  logic              feat_rdy_i,
    output logic              cls_start_o,
    output logic [31:0]       stage_threshold_o,
    output logic              stage_threshold_val_o,
    output logic              stage_last_o,
    input  logic              cls_next_stage_i,
    input  logic              cls_done_i,
    input  logic              cls_result_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAITROM,
        S_ISSUE,
        S_VERDICT
    } state_t;

    localparam logic [SA_W-1:0] LAST_IDX = SA_W'(NUM_STAGES - 1);

    state_t              state_q, state_d;
    logic [SA_W-1:0]     stage_idx_q, stage_idx_d;
    logic [FEAT_W-1:0]   feat_base_q, feat_base_d;
    logic [FEAT_W-1:0]   feat_off_q, feat_off_d;
    logic [FEAT_W-1:0]   feat_cnt_q, feat_cnt_d;
    logic [FEAT_W-1:0]   feat_idx_q, feat_idx_d;
    logic [31:0]         threshold_q, threshold_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                face_q, face_d;
    logic                err_q, err_d;
    logic                stage_rd_q, stage_rd_d;
    logic                feat_val_q, feat_val_d;
    logic                cls_start_q, cls_start_d;
    logic                thr_val_q, thr_val_d;
    logic                stage_last_q, stage_last_d;
    logic [SA_W-1:0]     next_idx;

    // NOTE: every _d gets its _q (or a strobe default) first, so no path
    // through the case statement leaves a variable unassigned and no latch forms.
    always_comb begin
        state_d      = state_q;
        stage_idx_d  = stage_idx_q;
        feat_base_d  = feat_base_q;
        feat_off_d   = feat_off_q;
        feat_cnt_d   = feat_cnt_q;
        feat_idx_d   = feat_idx_q;
        threshold_d  = threshold_q;
        busy_d       = busy_q;
        face_d       = face_q;
        err_d        = err_q;
        feat_val_d   = feat_val_q;
        stage_last_d = stage_last_q;
        done_d       = 1'b0;
        stage_rd_d   = 1'b0;
        cls_start_d  = 1'b0;
        thr_val_d    = 1'b0;
        next_idx     = stage_idx_q + SA_W'(1);

        // Classifier verdicts are only meaningful once all features are issued.
        if ((state_q == S_LOAD || state_q == S_WAITROM || state_q == S_ISSUE) &&
            (cls_next_stage_i || cls_done_i)) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    stage_idx_d  = '0;
                    feat_base_d  = '0;
                    feat_off_d   = '0;
                    err_d        = 1'b0;
                    face_d       = 1'b0;
                    cls_start_d  = 1'b1;
                    stage_rd_d   = 1'b1;
                    stage_last_d = (LAST_IDX == '0);
                    busy_d       = 1'b1;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_WAITROM;
            end
            S_WAITROM: begin
                if (stage_rdata_val_i) begin
                    feat_cnt_d  = stage_feat_cnt_i;
                    threshold_d = stage_threshold_i;
                    thr_val_d   = 1'b1;
                    if (stage_feat_cnt_i != '0) begin
                        feat_val_d = 1'b1;
                        feat_idx_d = feat_base_q;
                        state_d    = S_ISSUE;
                    end else begin
                        state_d = S_VERDICT;
                    end
                end
            end
            S_ISSUE: begin
                if (feat_rdy_i) begin
                    if (feat_off_q == feat_cnt_q - FEAT_W'(1)) begin
                        feat_val_d = 1'b0;
                        state_d    = S_VERDICT;
                    end else begin
                        feat_off_d = feat_off_q + FEAT_W'(1);
                        feat_idx_d = feat_base_q + feat_off_q + FEAT_W'(1);
                    end
                end
            end
            S_VERDICT: begin
                if (cls_done_i) begin
                    done_d       = 1'b1;
                    face_d       = stage_last_q & ~cls_result_i;
                    stage_last_d = 1'b0;
                    busy_d       = 1'b0;
                    state_d      = S_IDLE;
                end else if (cls_next_stage_i) begin
                    feat_base_d  = feat_base_q + feat_cnt_q;
                    stage_idx_d  = next_idx;
                    feat_off_d   = '0;
                    stage_rd_d   = 1'b1;
                    stage_last_d = (next_idx == LAST_IDX);
                    state_d      = S_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Abort wins over everything decided above, including a new error.
        if (abort_i) begin
            state_d      = S_IDLE;
            busy_d       = 1'b0;
            err_d        = err_q;
            face_d       = face_q;
            done_d       = 1'b0;
            stage_rd_d   = 1'b0;
            feat_val_d   = 1'b0;
            cls_start_d  = 1'b0;
            thr_val_d    = 1'b0;
            stage_last_d = 1'b0;
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every flop
    // samples the values computed from the previous cycle regardless of order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            stage_idx_q  <= '0;
            feat_base_q  <= '0;
            feat_off_q   <= '0;
            feat_cnt_q   <= '0;
            feat_idx_q   <= '0;
            threshold_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            face_q       <= 1'b0;
            err_q        <= 1'b0;
            stage_rd_q   <= 1'b0;
            feat_val_q   <= 1'b0;
            cls_start_q  <= 1'b0;
            thr_val_q    <= 1'b0;
            stage_last_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            stage_idx_q  <= stage_idx_d;
            feat_base_q  <= feat_base_d;
            feat_off_q   <= feat_off_d;
            feat_cnt_q   <= feat_cnt_d;
            feat_idx_q   <= feat_idx_d;
            threshold_q  <= threshold_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            face_q       <= face_d;
            err_q        <= err_d;
            stage_rd_q   <= stage_rd_d;
            feat_val_q   <= feat_val_d;
            cls_start_q  <= cls_start_d;
            thr_val_q    <= thr_val_d;
            stage_last_q <= stage_last_d;
        end
    end

    assign busy_o                = busy_q;
    assign done_o                = done_q;
    assign face_o                = face_q;
    assign err_o                 = err_q;
    assign stage_addr_o          = stage_idx_q;
    assign stage_rd_o            = stage_rd_q;
    assign feat_idx_o            = feat_idx_q;
    assign feat_val_o            = feat_val_q;
    assign cls_start_o           = cls_start_q;
    assign stage_threshold_o     = threshold_q;
    assign stage_threshold_val_o = thr_val_q;
    assign stage_last_o          = stage_last_q;

endmodule

// File: tb/tb_cascade_sequencer.sv
// Scoreboard bench for cascade_sequencer: a 3-stage cascade with a scripted ROM,
// feature sink and classifier; expectations are queued as stimulus is driven.
module tb_cascade_sequencer;

    localparam int NS  = 3;
    localparam int FW  = 12;
    localparam int SAW = $clog2(NS);

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic           start_i = 1'b0;
    logic           abort_i = 1'b0;
    logic           busy_o, done_o, face_o, err_o;
    logic [SAW-1:0] stage_addr_o;
    logic           stage_rd_o;
    logic           stage_rdata_val_i = 1'b0;
    logic [FW-1:0]  stage_feat_cnt_i = '0;
    logic [31:0]    stage_threshold_i = '0;
    logic [FW-1:0]  feat_idx_o;
    logic           feat_val_o;
    logic           feat_rdy_i = 1'b1;
    logic           cls_start_o;
    logic [31:0]    stage_threshold_o;
    logic           stage_threshold_val_o;
    logic           stage_last_o;
    logic           cls_next_stage_i = 1'b0;
    logic           cls_done_i = 1'b0;
    logic           cls_result_i = 1'b0;

    cascade_sequencer #(.NUM_STAGES(NS), .FEAT_W(FW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
        .busy_o(busy_o), .done_o(done_o), .face_o(face_o), .err_o(err_o),
        .stage_addr_o(stage_addr_o), .stage_rd_o(stage_rd_o),
        .stage_rdata_val_i(stage_rdata_val_i), .stage_feat_cnt_i(stage_feat_cnt_i),
        .stage_threshold_i(stage_threshold_i), .feat_idx_o(feat_idx_o),
        .feat_val_o(feat_val_o), .feat_rdy_i(feat_rdy_i), .cls_start_o(cls_start_o),
        .stage_threshold_o(stage_threshold_o),
        .stage_threshold_val_o(stage_threshold_val_o), .stage_last_o(stage_last_o),
        .cls_next_stage_i(cls_next_stage_i), .cls_done_i(cls_done_i),
        .cls_result_i(cls_result_i)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_idx_q[$];
    int          exp_rd_q[$];
    logic [31:0] exp_thr_q[$];
    bit          exp_face_q[$];
    bit          exp_last_cur = 1'b0;
    int          stage_hs = 0;
    int          stall_at = 0;
    int          stall_left = 0;
    int          cls_start_cnt = 0;
    bit          prev_stall = 1'b0;
    logic [FW-1:0] prev_idx = '0;
    int          cfg_cnt[NS];
    int          cfg_lat[NS];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every DUT event.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            prev_stall = 1'b0;
        end else begin
            if (stage_rd_o) begin
                check("rd_expected", 32'(exp_rd_q.size() != 0), 1);
                if (exp_rd_q.size() != 0) begin
                    int a;
                    a = exp_rd_q.pop_front();
                    exp_last_cur = (a == NS - 1);
                    check("rd_addr", 32'(stage_addr_o), a);
                    check("rd_last", 32'(stage_last_o), 32'(exp_last_cur));
                end
            end
            if (stage_threshold_val_o) begin
                check("thr_expected", 32'(exp_thr_q.size() != 0), 1);
                if (exp_thr_q.size() != 0)
                    check("thr_value", stage_threshold_o, exp_thr_q.pop_front());
            end
            if (feat_val_o)
                check("last_hold", 32'(stage_last_o), 32'(exp_last_cur));
            if (prev_stall && feat_val_o)
                check("idx_hold", 32'(feat_idx_o), 32'(prev_idx));
            if (feat_val_o && feat_rdy_i) begin
                check("idx_expected", 32'(exp_idx_q.size() != 0), 1);
                if (exp_idx_q.size() != 0)
                    check("feat_idx", 32'(feat_idx_o), exp_idx_q.pop_front());
                stage_hs++;
            end
            if (done_o) begin
                check("done_expected", 32'(exp_face_q.size() != 0), 1);
                if (exp_face_q.size() != 0)
                    check("face", 32'(face_o), 32'(exp_face_q.pop_front()));
            end
            if (cls_start_o) cls_start_cnt++;
            prev_stall = feat_val_o && !feat_rdy_i;
            prev_idx   = feat_idx_o;
        end
    end

    // Feature sink: stalls stall_left cycles once stage_hs features were taken.
    always @(posedge clk_i) begin
        #1;
        if (feat_val_o && stall_left > 0 && stage_hs == stall_at) begin
            feat_rdy_i = 1'b0;
            stall_left--;
        end else begin
            feat_rdy_i = 1'b1;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy_o), 0);
        check({tag, "_done"}, 32'(done_o), 0);
        check({tag, "_face"}, 32'(face_o), 0);
        check({tag, "_err"}, 32'(err_o), 0);
        check({tag, "_addr"}, 32'(stage_addr_o), 0);
        check({tag, "_rd"}, 32'(stage_rd_o), 0);
        check({tag, "_idx"}, 32'(feat_idx_o), 0);
        check({tag, "_val"}, 32'(feat_val_o), 0);
        check({tag, "_cls_start"}, 32'(cls_start_o), 0);
        check({tag, "_thr"}, stage_threshold_o, 0);
        check({tag, "_thr_val"}, 32'(stage_threshold_val_o), 0);
        check({tag, "_last"}, 32'(stage_last_o), 0);
    endtask

    task automatic do_start();
        cls_start_cnt = 0;
        exp_rd_q.push_back(0);
        @(posedge clk_i); #1 start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
    endtask

    task automatic wait_rd();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_i);
            seen = stage_rd_o;
        end
        check("rd_seen", 32'(seen), 1);
        @(posedge clk_i); #1;
    endtask

    // Serve one stage from the ROM and wait until the DUT sits in VERDICT.
    task automatic do_stage(input int cnt, input int lat, input int base,
                            input bit poke_start, input bit inject_next);
        bit seen = 1'b0;
        logic [31:0] thr;
        wait_rd();
        if (poke_start) begin
            start_i = 1'b1;
            @(posedge clk_i); #1 start_i = 1'b0;
        end
        repeat (lat) begin @(posedge clk_i); #1; end
        thr = $urandom;
        exp_thr_q.push_back(thr);
        for (int k = 0; k < cnt; k++) exp_idx_q.push_back((base + k) % (1 << FW));
        stage_hs          = 0;
        stage_rdata_val_i = 1'b1;
        stage_feat_cnt_i  = FW'(cnt);
        stage_threshold_i = thr;
        @(posedge clk_i); #1 stage_rdata_val_i = 1'b0;
        stage_threshold_i = 32'hdead_beef;
        if (inject_next) begin
            @(posedge clk_i); #1;
            @(posedge clk_i); #1 cls_next_stage_i = 1'b1;
            @(posedge clk_i); #1 cls_next_stage_i = 1'b0;
            check("err_set", 32'(err_o), 1);
        end
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk_i);
            seen = (stage_hs == cnt) && !feat_val_o;
        end
        check("verdict_reached", 32'(seen), 1);
        if (cnt == 0) check("no_feat_val", 32'(feat_val_o), 0);
    endtask

    task automatic do_verdict(input bit done, input bit nxt, input bit res, input bit exp_face);
        if (done) exp_face_q.push_back(exp_face);
        @(posedge clk_i); #1;
        cls_done_i = done; cls_next_stage_i = nxt; cls_result_i = res;
        @(posedge clk_i); #1;
        cls_done_i = 1'b0; cls_next_stage_i = 1'b0; cls_result_i = 1'b0;
    endtask

    task automatic finish_window(input string tag);
        repeat (4) @(negedge clk_i);
        check({tag, "_busy_idle"}, 32'(busy_o), 0);
        check({tag, "_idx_left"}, exp_idx_q.size(), 0);
        check({tag, "_rd_left"}, exp_rd_q.size(), 0);
        check({tag, "_thr_left"}, exp_thr_q.size(), 0);
        check({tag, "_done_left"}, exp_face_q.size(), 0);
        check({tag, "_cls_start_once"}, cls_start_cnt, 1);
    endtask

    task automatic run_window(input string tag, input int n, input bit res, input int poke_stage);
        int base = 0;
        do_start();
        check({tag, "_busy"}, 32'(busy_o), 1);
        for (int s = 0; s < n; s++) begin
            do_stage(cfg_cnt[s], cfg_lat[s], base, s == poke_stage, 1'b0);
            base += cfg_cnt[s];
            if (s < n - 1) begin
                exp_rd_q.push_back(s + 1);
                do_verdict(1'b0, 1'b1, 1'b0, 1'b0);
            end else begin
                do_verdict(1'b1, 1'b0, res, (s == NS - 1) && !res);
            end
        end
        finish_window(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #3 check_all_zero("reset");
        #20 rst_ni = 1'b1;

        // Full pass with staggered ROM latency and a stray start in WAITROM.
        cfg_cnt = '{2, 3, 1};
        cfg_lat = '{0, 2, 1};
        run_window("pass", 3, 1'b0, 1);

        // Early reject in stage 0: no read of stage 1 may follow.
        cfg_cnt = '{2, 0, 0};
        cfg_lat = '{1, 0, 0};
        run_window("reject", 1, 1'b1, -1);

        // Backpressure on the 2nd feature plus a zero-feature middle stage.
        cfg_cnt = '{3, 0, 2};
        cfg_lat = '{1, 0, 3};
        stall_at = 1; stall_left = 3;
        run_window("bp", 3, 1'b0, -1);

        // Protocol error in ISSUE, then simultaneous done/next in VERDICT.
        stall_at = 1; stall_left = 5;
        do_start();
        do_stage(3, 1, 0, 1'b0, 1'b1);
        do_verdict(1'b1, 1'b1, 1'b0, 1'b0);
        finish_window("both");
        check("err_sticky", 32'(err_o), 1);

        // Next start clears err; abort in ISSUE returns to IDLE without done.
        stall_at = 1; stall_left = 5;
        do_start();
        check("err_clear", 32'(err_o), 0);
        wait_rd();
        exp_thr_q.push_back(32'h3f80_0000);
        for (int k = 0; k < 4; k++) exp_idx_q.push_back(k);
        stage_hs = 0;
        stage_rdata_val_i = 1'b1; stage_feat_cnt_i = FW'(4); stage_threshold_i = 32'h3f80_0000;
        @(posedge clk_i); #1 stage_rdata_val_i = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1 abort_i = 1'b1;
        @(posedge clk_i); #1 abort_i = 1'b0;
        check("abort_busy", 32'(busy_o), 0);
        check("abort_val", 32'(feat_val_o), 0);
        check("abort_done", 32'(done_o), 0);
        check("abort_last", 32'(stage_last_o), 0);
        exp_idx_q.delete();
        stall_left = 0;
        finish_window("abort");

        // Reset asserted in WAITROM clears every output immediately.
        do_start();
        wait_rd();
        check("waitrom_busy", 32'(busy_o), 1);
        #2 rst_ni = 1'b0;
        #1 check_all_zero("rst_mid");
        @(negedge clk_i) rst_ni = 1'b1;
        exp_idx_q.delete(); exp_rd_q.delete(); exp_thr_q.delete(); exp_face_q.delete();
        repeat (8) @(negedge clk_i);
        check("post_rst_busy", 32'(busy_o), 0);
        check("post_rst_done_left", exp_face_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
